// File: rtl/memory_pkg.sv
// Shared definitions for the latency-modelling memory: controller state encoding
// and an elaboration-time ceiling-log2 helper.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/latency_counter.sv
// Down-counter that times one memory access; loads on accept and flags zero
// at the edge on which the access completes.
module latency_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_value,
    input  logic             load,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Holds at zero once expired so it never wraps while the FSM completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/memory_latency.sv
// Word memory with byte enables that answers each read or write after a fixed,
// per-operation latency, one request in flight at a time.
module memory_latency
    import memory_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int DEPTH       = 256,
    parameter  int DELAY_READ  = 2,
    parameter  int DELAY_WRITE = 2,
    localparam int ADDR_WIDTH  = clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    read,
    input  logic                    write,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    done,
    output logic                    error
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int MAX_DELAY = (DELAY_READ > DELAY_WRITE) ? DELAY_READ : DELAY_WRITE;
    localparam int CNT_WIDTH = clog2(MAX_DELAY) + 1;
    localparam logic [CNT_WIDTH-1:0] READ_LOAD  = CNT_WIDTH'(DELAY_READ - 1);
    localparam logic [CNT_WIDTH-1:0] WRITE_LOAD = CNT_WIDTH'(DELAY_WRITE - 1);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
        $error("memory_latency: DATA_WIDTH must be a positive multiple of 8");
    end
    if (DELAY_READ < 1 || DELAY_WRITE < 1) begin : g_bad_delay
        $error("memory_latency: DELAY_READ and DELAY_WRITE must be at least 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("memory_latency: DEPTH must be at least 2");
    end

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [BYTES-1:0]        be_q;
    logic                    fault_q;
    logic                    oob_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    accept;
    logic                    cnt_zero;

    assign ready  = (state == IDLE);
    assign accept = (state == IDLE) && (read || write);

    latency_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_latency_counter (
        .clk        (clk),
        .reset      (reset),
        .load_value (write ? WRITE_LOAD : READ_LOAD),
        .load       (accept),
        .enable     (state != IDLE),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            be_q     <= '0;
            fault_q  <= 1'b0;
            oob_q    <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            data_out <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            done     <= 1'b0;
            error    <= 1'b0;
            data_out <= '0;
            case (state)
                IDLE: begin
                    if (read || write) begin
                        addr_q  <= address;
                        data_q  <= data_in;
                        be_q    <= byte_en;
                        oob_q   <= !(32'(address) < DEPTH);
                        // A simultaneous read+write runs as a write but is reported.
                        fault_q <= (read && write) || !(32'(address) < DEPTH);
                        state   <= write ? WRITE_WAIT : READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (cnt_zero) begin
                        state    <= IDLE;
                        done     <= 1'b1;
                        error    <= fault_q;
                        data_out <= oob_q ? '0 : mem[addr_q];
                    end
                end
                WRITE_WAIT: begin
                    if (cnt_zero) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        error <= fault_q;
                        if (!oob_q) begin
                            for (int b = 0; b < BYTES; b++) begin
                                if (be_q[b]) begin
                                    mem[addr_q][b*8 +: 8] <= data_q[b*8 +: 8];
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_latency.sv
// Directed bench for memory_latency: four parameterisations share one stimulus
// bus, selected by sel, with hand-computed expected results.
module tb_memory_latency;

    logic        clk;
    logic        reset0;
    logic        reset1;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    int          sel;

    logic        rdy0, dn0, er0, rdy1, dn1, er1, rdy2, dn2, er2, rdy3, dn3, er3;
    logic [7:0]  do0, do2, do3;
    logic [31:0] do1;

    logic        got_ready;
    logic        got_done;
    logic        got_err;
    logic [31:0] got_dout;

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    memory_latency u0 (
        .clk(clk), .reset(reset0), .address(addr), .data_in(din[7:0]), .byte_en(be[0:0]),
        .read(rd && sel == 0), .write(wr && sel == 0),
        .ready(rdy0), .data_out(do0), .done(dn0), .error(er0)
    );

    memory_latency #(.DATA_WIDTH(32)) u1 (
        .clk(clk), .reset(reset1), .address(addr), .data_in(din), .byte_en(be),
        .read(rd && sel == 1), .write(wr && sel == 1),
        .ready(rdy1), .data_out(do1), .done(dn1), .error(er1)
    );

    memory_latency #(.DELAY_READ(1), .DELAY_WRITE(3)) u2 (
        .clk(clk), .reset(reset1), .address(addr), .data_in(din[7:0]), .byte_en(be[0:0]),
        .read(rd && sel == 2), .write(wr && sel == 2),
        .ready(rdy2), .data_out(do2), .done(dn2), .error(er2)
    );

    memory_latency #(.DEPTH(200)) u3 (
        .clk(clk), .reset(reset1), .address(addr), .data_in(din[7:0]), .byte_en(be[0:0]),
        .read(rd && sel == 3), .write(wr && sel == 3),
        .ready(rdy3), .data_out(do3), .done(dn3), .error(er3)
    );

    always_comb begin
        got_ready = rdy0;
        got_done  = dn0;
        got_err   = er0;
        got_dout  = {24'h0, do0};
        case (sel)
            1: begin got_ready = rdy1; got_done = dn1; got_err = er1; got_dout = do1; end
            2: begin got_ready = rdy2; got_done = dn2; got_err = er2; got_dout = {24'h0, do2}; end
            3: begin got_ready = rdy3; got_done = dn3; got_err = er3; got_dout = {24'h0, do3}; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the done cycle.
    task automatic do_req(input logic r, input logic w, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output int lat, output logic [31:0] dout, output logic err);
        rd = r; wr = w; addr = a; din = d; be = b;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0; addr = ~a; din = ~d; be = ~b;
        lat  = -1;
        dout = 32'hdead_beef;
        err  = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) check("ready_busy", 32'(got_ready), 32'd0);
            if (got_done) begin
                lat  = k - 1;
                dout = got_dout;
                err  = got_err;
                check("ready_in_done", 32'(got_ready), 32'd1);
                break;
            end
        end
    endtask

    int          lat;
    logic [31:0] dout;
    logic        err;
    int          done_seen;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel = 0; rd = 0; wr = 0; addr = 0; din = 0; be = 0;
        reset0 = 1'b1;
        reset1 = 1'b1;
        #12;
        check("rst_ready", 32'(rdy0), 32'd1);
        check("rst_done", 32'(dn0), 32'd0);
        check("rst_error", 32'(er0), 32'd0);
        check("rst_dout", 32'(do0), 32'd0);
        @(negedge clk);
        reset0 = 1'b0;
        reset1 = 1'b0;

        // default instance: write then read back, first request right after reset
        sel = 0;
        do_req(1'b0, 1'b1, 8'd3, 32'hA5, 4'h1, lat, dout, err);
        check("wr_lat", 32'(lat), 32'd2);
        check("wr_err", 32'(err), 32'd0);
        do_req(1'b1, 1'b0, 8'd3, 32'h00, 4'h0, lat, dout, err);
        check("rd_lat", 32'(lat), 32'd2);
        check("rd_data", dout, 32'hA5);
        check("rd_err", 32'(err), 32'd0);
        @(negedge clk);
        check("dout_idle", got_dout, 32'h0);
        check("done_idle", 32'(got_done), 32'd0);

        // read+write together behaves as a write and flags error
        do_req(1'b1, 1'b1, 8'd7, 32'h3C, 4'h1, lat, dout, err);
        check("rw_lat", 32'(lat), 32'd2);
        check("rw_err", 32'(err), 32'd1);
        do_req(1'b1, 1'b0, 8'd7, 32'h00, 4'h0, lat, dout, err);
        check("rw_readback", dout, 32'h3C);
        check("rw_readback_err", 32'(err), 32'd0);

        // 32-bit words with partial byte enables
        sel = 1;
        do_req(1'b0, 1'b1, 8'd5, 32'h1122_3344, 4'hF, lat, dout, err);
        check("w32_full_lat", 32'(lat), 32'd2);
        do_req(1'b0, 1'b1, 8'd5, 32'hAABB_CCDD, 4'h5, lat, dout, err);
        check("w32_part_err", 32'(err), 32'd0);
        do_req(1'b1, 1'b0, 8'd5, 32'h0, 4'h0, lat, dout, err);
        check("w32_merge", dout, 32'h11BB_33DD);

        // asymmetric latency, each request presented in the previous done cycle
        sel = 2;
        do_req(1'b0, 1'b1, 8'd1, 32'h5A, 4'h1, lat, dout, err);
        check("asym_wr1_lat", 32'(lat), 32'd3);
        do_req(1'b1, 1'b0, 8'd1, 32'h0, 4'h0, lat, dout, err);
        check("asym_rd1_lat", 32'(lat), 32'd1);
        check("asym_rd1_data", dout, 32'h5A);
        do_req(1'b0, 1'b1, 8'd2, 32'h66, 4'h1, lat, dout, err);
        check("asym_wr2_lat", 32'(lat), 32'd3);
        do_req(1'b1, 1'b0, 8'd2, 32'h0, 4'h0, lat, dout, err);
        check("asym_rd2_lat", 32'(lat), 32'd1);
        check("asym_rd2_data", dout, 32'h66);

        // out-of-range addresses on a non-power-of-two depth
        sel = 3;
        do_req(1'b0, 1'b1, 8'd10, 32'h77, 4'h1, lat, dout, err);
        check("oob_inrange_err", 32'(err), 32'd0);
        do_req(1'b0, 1'b1, 8'd210, 32'h99, 4'h1, lat, dout, err);
        check("oob_wr_lat", 32'(lat), 32'd2);
        check("oob_wr_err", 32'(err), 32'd1);
        do_req(1'b1, 1'b0, 8'd210, 32'h0, 4'h0, lat, dout, err);
        check("oob_rd_lat", 32'(lat), 32'd2);
        check("oob_rd_data", dout, 32'h0);
        check("oob_rd_err", 32'(err), 32'd1);
        do_req(1'b1, 1'b0, 8'd10, 32'h0, 4'h0, lat, dout, err);
        check("oob_mem_intact", dout, 32'h77);

        // reset one edge after accepting a write aborts it
        sel = 0;
        rd = 1'b0; wr = 1'b1; addr = 8'd9; din = 32'hEE; be = 4'h1;
        @(posedge clk);
        #1;
        wr = 1'b0;
        @(posedge clk);
        #1;
        reset0 = 1'b1;
        #1;
        check("abort_done", 32'(dn0), 32'd0);
        check("abort_ready", 32'(rdy0), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset0 = 1'b0;
        check("abort_ready_release", 32'(rdy0), 32'd1);
        done_seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (dn0) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        @(negedge clk);
        do_req(1'b1, 1'b0, 8'd9, 32'h0, 4'h0, lat, dout, err);
        check("abort_rd_lat", 32'(lat), 32'd2);
        check("abort_rd_data", dout, 32'h0);
        do_req(1'b1, 1'b0, 8'd3, 32'h0, 4'h0, lat, dout, err);
        check("reset_cleared_mem", dout, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
